// File: rtl/johnson_phase_monitor.sv
// Johnson-code phase monitor: decodes a 2N-phase Johnson code, tracks sequence legality, and reports lock, wrap and error status.
// Optional build macro JPM_STALL_ALLOW_EN: when defined, a repeated phase index is treated as a benign stall.
module johnson_phase_monitor #(
    parameter int N        = 4,
    parameter int LOCK_CNT = 8,
    parameter int ERR_W    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [N-1:0]           jc_in,
    input  logic                   clr_err,
    output logic [2*N-1:0]         phase_oh,
    output logic [$clog2(2*N)-1:0] phase_idx,
    output logic                   illegal,
    output logic                   wrap_pulse,
    output logic                   seq_err,
    output logic                   locked,
    output logic [ERR_W-1:0]       err_cnt
);
    localparam int IDX_W = $clog2(2*N);
    localparam int CNT_W = $clog2(LOCK_CNT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2*N - 1);

    typedef enum logic [1:0] {ACQ = 2'd0, TRACK = 2'd1, LOCKED = 2'd2} state_t;

    // Returns {legal, index}; the legal code for index k is built from a shifted all-ones mask.
    function automatic logic [IDX_W:0] decode_jc(input logic [N-1:0] code);
        logic [IDX_W:0] res;
        logic [N-1:0]   ones;
        logic [N-1:0]   pat;
        res  = '0;
        ones = '1;
        for (int k = 0; k < 2*N; k++) begin
            if (k <= N) begin
                pat = ~(ones << k);
            end else begin
                pat = ones << (k - N);
            end
            if (code == pat) begin
                res = {1'b1, IDX_W'(k)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    state_t           state_r, state_s;
    logic [IDX_W-1:0] ref_idx_r, ref_idx_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [2*N-1:0]   phase_oh_r, phase_oh_s;
    logic [IDX_W-1:0] phase_idx_r, phase_idx_s;
    logic             illegal_r, illegal_s;
    logic             wrap_r, wrap_s;
    logic             seq_err_r, seq_err_s;
    logic             locked_r, locked_s;
    logic [ERR_W-1:0] err_cnt_r, err_cnt_s;

    logic [IDX_W:0]   dec_s;
    logic             code_ok_s;
    logic [IDX_W-1:0] new_idx_s;
    logic [IDX_W-1:0] exp_idx_s;
    logic             step_ok_s;
    logic [CNT_W-1:0] cnt_inc_s;

    assign dec_s     = decode_jc(jc_in);
    assign code_ok_s = dec_s[IDX_W];
    assign new_idx_s = dec_s[IDX_W-1:0];
    assign exp_idx_s = (ref_idx_r == LAST_IDX) ? '0 : ref_idx_r + IDX_W'(1);
    assign step_ok_s = code_ok_s && (new_idx_s == exp_idx_s);
    assign cnt_inc_s = cnt_r + CNT_W'(1);
`ifdef JPM_STALL_ALLOW_EN
    logic is_repeat_s;
    assign is_repeat_s = code_ok_s && (new_idx_s == ref_idx_r);
`endif

    // Next-state and next-output decode for the acquire/track/lock sequencer.
    always_comb begin
        state_s     = state_r;
        ref_idx_s   = ref_idx_r;
        cnt_s       = cnt_r;
        phase_oh_s  = phase_oh_r;
        phase_idx_s = phase_idx_r;
        illegal_s   = illegal_r;
        wrap_s      = 1'b0;
        seq_err_s   = 1'b0;
        locked_s    = locked_r;
        if (en) begin
            illegal_s = ~code_ok_s;
            if (code_ok_s) begin
                phase_oh_s  = {{(2*N-1){1'b0}}, 1'b1} << new_idx_s;
                phase_idx_s = new_idx_s;
            end else begin
                phase_oh_s  = '0;
            end
            case (state_r)
                ACQ: begin
                    if (code_ok_s) begin
                        ref_idx_s = new_idx_s;
                        cnt_s     = '0;
                        state_s   = TRACK;
                    end else begin
                        seq_err_s = 1'b1;
                    end
                end
                TRACK, LOCKED: begin
                    if (!code_ok_s) begin
                        seq_err_s = 1'b1;
                        cnt_s     = '0;
                        state_s   = ACQ;
                    end else if (step_ok_s) begin
                        ref_idx_s = new_idx_s;
                        wrap_s    = (ref_idx_r == LAST_IDX);
                        if (state_r == TRACK) begin
                            cnt_s   = cnt_inc_s;
                            state_s = (cnt_inc_s == CNT_W'(LOCK_CNT)) ? LOCKED : TRACK;
                        end else begin
                            state_s = LOCKED;
                        end
                    end
`ifdef JPM_STALL_ALLOW_EN
                    else if (is_repeat_s) begin
                        state_s = state_r;
                    end
`endif
                    else begin
                        seq_err_s = 1'b1;
                        ref_idx_s = new_idx_s;
                        cnt_s     = '0;
                        state_s   = TRACK;
                    end
                end
                default: begin
                    state_s = ACQ;
                    cnt_s   = '0;
                end
            endcase
            locked_s = (state_s == LOCKED);
        end else begin
            state_s = state_r;
        end
    end

    // Saturating error counter; clear wins over hold but still counts a coincident error.
    always_comb begin
        err_cnt_s = err_cnt_r;
        if (clr_err) begin
            err_cnt_s = seq_err_s ? ERR_W'(1) : '0;
        end else if (seq_err_s && !(&err_cnt_r)) begin
            err_cnt_s = err_cnt_r + ERR_W'(1);
        end else begin
            err_cnt_s = err_cnt_r;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ACQ;
            ref_idx_r   <= '0;
            cnt_r       <= '0;
            phase_oh_r  <= '0;
            phase_idx_r <= '0;
            illegal_r   <= 1'b0;
            wrap_r      <= 1'b0;
            seq_err_r   <= 1'b0;
            locked_r    <= 1'b0;
            err_cnt_r   <= '0;
        end else begin
            state_r     <= state_s;
            ref_idx_r   <= ref_idx_s;
            cnt_r       <= cnt_s;
            phase_oh_r  <= phase_oh_s;
            phase_idx_r <= phase_idx_s;
            illegal_r   <= illegal_s;
            wrap_r      <= wrap_s;
            seq_err_r   <= seq_err_s;
            locked_r    <= locked_s;
            err_cnt_r   <= err_cnt_s;
        end
    end

    assign phase_oh   = phase_oh_r;
    assign phase_idx  = phase_idx_r;
    assign illegal    = illegal_r;
    assign wrap_pulse = wrap_r;
    assign seq_err    = seq_err_r;
    assign locked     = locked_r;
    assign err_cnt    = err_cnt_r;
endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Directed self-checking bench for johnson_phase_monitor (N=4, LOCK_CNT=8, ERR_W=8).
module tb_johnson_phase_monitor;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic [3:0] jc_in = 4'b0000;
    logic       clr_err = 1'b0;
    logic [7:0] phase_oh;
    logic [2:0] phase_idx;
    logic       illegal, wrap_pulse, seq_err, locked;
    logic [7:0] err_cnt;

    int n_chk = 0;
    int n_fail = 0;
    int err_after_stall;
    logic [3:0] lseq [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                             4'b1111, 4'b1110, 4'b1100, 4'b1000};

    johnson_phase_monitor #(.N(4), .LOCK_CNT(8), .ERR_W(8)) dut (
        .clk(clk), .reset(reset), .en(en), .jc_in(jc_in), .clr_err(clr_err),
        .phase_oh(phase_oh), .phase_idx(phase_idx), .illegal(illegal),
        .wrap_pulse(wrap_pulse), .seq_err(seq_err), .locked(locked), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic sample(input logic e, input logic [3:0] c, input logic clr);
        en = e;
        jc_in = c;
        clr_err = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] oh, input logic [2:0] idx,
                           input logic ill, input logic wrp, input logic serr,
                           input logic lck, input logic [7:0] ecnt);
        chk({tag, ".phase_oh"}, 32'(phase_oh), 32'(oh));
        chk({tag, ".phase_idx"}, 32'(phase_idx), 32'(idx));
        chk({tag, ".illegal"}, 32'(illegal), 32'(ill));
        chk({tag, ".wrap_pulse"}, 32'(wrap_pulse), 32'(wrp));
        chk({tag, ".seq_err"}, 32'(seq_err), 32'(serr));
        chk({tag, ".locked"}, 32'(locked), 32'(lck));
        chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(ecnt));
    endtask

    initial begin
        sample(1'b0, 4'b0000, 1'b0);
        chk_all("reset", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        reset = 1'b0;

        // Acquire and lock on the legal sequence, with an en gap after 0011.
        sample(1'b1, 4'b0000, 1'b0);
        chk_all("s0", 8'h01, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        sample(1'b1, 4'b0001, 1'b0);
        chk_all("s1", 8'h02, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        sample(1'b1, 4'b0011, 1'b0);
        chk_all("s2", 8'h04, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        sample(1'b0, 4'b0101, 1'b0);
        chk_all("en_gap1", 8'h04, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        sample(1'b0, 4'b0101, 1'b0);
        chk_all("en_gap2", 8'h04, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        for (int i = 3; i < 8; i++) begin
            sample(1'b1, lseq[i], 1'b0);
            chk_all("lock_seq", 8'(1 << i), 3'(i), 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        end
        sample(1'b1, 4'b0000, 1'b0);
        chk_all("lock_9th", 8'h01, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0);
        sample(1'b1, 4'b0001, 1'b0);
        chk_all("locked_step", 8'h02, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);

        // Illegal code while locked, then reacquire.
        sample(1'b1, 4'b0101, 1'b0);
        chk_all("locked_illegal", 8'h00, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1);
        sample(1'b1, 4'b0011, 1'b0);
        chk_all("reacquire", 8'h04, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);

        // Illegal transitions in TRACK, then count to lock from count=1.
        sample(1'b1, 4'b0001, 1'b0);
        chk_all("track_back", 8'h02, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2);
        sample(1'b1, 4'b0111, 1'b0);
        chk_all("track_skip", 8'h08, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3);
        sample(1'b1, 4'b1111, 1'b0);
        chk_all("track_resume", 8'h10, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3);
        for (int i = 5; i < 8; i++) begin
            sample(1'b1, lseq[i], 1'b0);
            chk_all("track_cnt", 8'(1 << i), 3'(i), 1'b0, 1'b0, 1'b0, 1'b0, 8'd3);
        end
        sample(1'b1, 4'b0000, 1'b0);
        chk_all("track_wrap", 8'h01, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3);
        sample(1'b1, 4'b0001, 1'b0);
        chk_all("track_c6", 8'h02, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3);
        sample(1'b1, 4'b0011, 1'b0);
        chk_all("track_c7", 8'h04, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3);
        sample(1'b1, 4'b0111, 1'b0);
        chk_all("track_c8", 8'h08, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3);

        // Drop to TRACK, then repeat the same index.
        sample(1'b1, 4'b0011, 1'b0);
        chk_all("locked_back", 8'h04, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 8'd4);
        sample(1'b1, 4'b0011, 1'b0);
`ifdef JPM_STALL_ALLOW_EN
        err_after_stall = 4;
        chk_all("repeat_stall", 8'h04, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4);
`else
        err_after_stall = 5;
        chk_all("repeat_err", 8'h04, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 8'd5);
`endif

        // Saturate the error counter, then clear with a coincident error.
        for (int i = 0; i < 255 - err_after_stall; i++) begin
            sample(1'b1, 4'b0101, 1'b0);
        end
        chk_all("sat_reach", 8'h00, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 8'd255);
        sample(1'b1, 4'b0101, 1'b0);
        chk_all("sat_hold", 8'h00, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 8'd255);
        sample(1'b1, 4'b0101, 1'b1);
        chk_all("clr_with_err", 8'h00, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1);
        sample(1'b0, 4'b0000, 1'b1);
        chk_all("clr_idle", 8'h00, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);

        // Relock, then reset while locked.
        for (int i = 0; i < 8; i++) begin
            sample(1'b1, lseq[i], 1'b0);
            chk_all("relock_seq", 8'(1 << i), 3'(i), 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        end
        sample(1'b1, 4'b0000, 1'b0);
        chk_all("relock", 8'h01, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0);
        reset = 1'b1;
        sample(1'b1, 4'b0001, 1'b0);
        chk_all("reset_locked", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        reset = 1'b0;

        // Counter restarting mid-stream is an illegal transition.
        sample(1'b1, 4'b0001, 1'b0);
        chk_all("post_reset_acq", 8'h02, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        sample(1'b1, 4'b0011, 1'b0);
        chk_all("post_reset_step", 8'h04, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        sample(1'b1, 4'b0000, 1'b0);
        chk_all("midstream_zero", 8'h01, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/johnson_phase_monitor.md
Name: johnson_phase_monitor

Overview:
- Sits directly downstream of the 4-bit Johnson counter and consumes its q output every sampled cycle.
- Decodes the Johnson code into a one-hot phase and a binary phase index.
- Checks that successive codes follow the legal Johnson sequence, and reports lock, wrap and error status to downstream sequencing logic.

Parameters:
- N, 4, Johnson counter width; the block decodes 2N phases.
- LOCK_CNT, 8, number of consecutive legal transitions required before locked asserts.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  sample-valid: jc_in is evaluated only on cycles where en=1.
- jc_in  in  N  Johnson code from the counter.
- clr_err  in  1  synchronous clear of err_cnt.
- phase_oh  out  2N  registered one-hot phase; all zeros when the code is illegal.
- phase_idx  out  clog2(2N)  registered phase index; holds the last legal value.
- illegal  out  1  registered; last sampled code is not a legal Johnson code.
- wrap_pulse  out  1  one-cycle pulse on a legal transition from index 2N-1 to 0.
- seq_err  out  1  one-cycle pulse on an illegal code or an illegal transition.
- locked  out  1  high in the LOCKED state.
- err_cnt  out  ERR_W  saturating count of seq_err events.

Behaviour:
- Clock and reset: reset is synchronous and active-high; clock is clk.
- Reset values: all outputs are 0, FSM state is ACQ, good-transition count is 0, reference invalid.
- Legal code decode for index k:
  - k=0..N: the low k bits are 1 and all other bits are 0.
  - k=N+1..2N-1: the top 2N-k bits are 1 and all other bits are 0.
  - Example for N=4: 0000,0001,0011,0111,1111,1110,1100,1000 map to idx 0..7.
  - Any other code is illegal.
- Latency: outputs reflect the sample taken with en=1 one cycle later, at the next rising edge.
- en=0: all registered outputs hold; wrap_pulse and seq_err are 0.
- Legal transition: new_idx == (ref_idx+1) mod 2N. Any other relation, including a repeat of the same index, is an illegal transition.
- FSM:
  - ACQ:
    - Illegal code: illegal=1, seq_err=1, stay in ACQ.
    - Legal code: capture as reference, go to TRACK with count 0, no error.
  - TRACK:
    - Legal transition: count+1 and update the reference. When count reaches LOCK_CNT, go to LOCKED; locked is visible with the outputs of that same sample.
    - Legal code but illegal transition: seq_err=1, reference = new code, count 0, stay in TRACK.
    - Illegal code: seq_err=1, go to ACQ, reference invalid.
  - LOCKED:
    - Legal transition: stay in LOCKED.
    - Legal code but illegal transition: seq_err=1, go to TRACK with count 0.
    - Illegal code: seq_err=1, go to ACQ.
    - locked drops with the error.
- wrap_pulse: asserted only on a legal transition in TRACK or LOCKED, never on the first sample in ACQ.
- err_cnt:
  - Increments by 1 on each seq_err and saturates at all-ones.
  - clr_err has priority over hold; clr_err together with seq_err in the same cycle gives err_cnt=1.
  - reset has priority over everything.
- Counter reset mid-stream (jc_in jumps to 0000 from a non-7 index) is an illegal transition: seq_err, and the block drops to TRACK.
- reset asserted mid-LOCKED: all state and outputs are at reset values after the next edge.

Optional Feature:
- Macro: JPM_STALL_ALLOW_EN.
- Defined: a repeated index is a stall. No seq_err, the good-transition count is unchanged, state is unchanged, and wrap_pulse is 0.
- Undefined: a repeated index is an illegal transition as specified above.

Test Plan:
- Reset, then en=1 with the legal sequence starting at 0000 (N=4, LOCK_CNT=8):
  - At sample 0011: phase_oh=8'b00000100, idx=2.
  - locked=1 at the output of the 9th sample (0000 again), together with wrap_pulse=1 and idx=0.
  - err_cnt stays 0.
- While LOCKED, feed 0101:
  - Response: illegal=1, seq_err=1, err_cnt=1, locked=0, phase_oh=0, phase_idx holds its previous value.
  - Then feed 0011: no error, state TRACK.
- In TRACK, feed 0001 then 0111 (skip):
  - Response: seq_err=1, err_cnt increments, reference idx=3.
  - Then 1111: legal, count=1.
- Toggle en 1,0,0,1 during the legal sequence: outputs hold during the en=0 cycles, no pulses, and lock progress is unaffected.
- Force err_cnt to 255 with repeated illegal codes:
  - One more error leaves err_cnt=255.
  - clr_err together with an error gives err_cnt=1.
  - Assert reset while LOCKED: all outputs are 0 next cycle.
- Feed 0011,0011 in TRACK:
  - Macro undefined: seq_err=1.
  - JPM_STALL_ALLOW_EN defined: seq_err=0 and count unchanged.
